cpu_commit_stage: RTL and testbench

Memory/commit pipeline stage. Consumes the execute-stage bundle (mem ctrl, wb ctrl, ALU result, rb data, dest reg) and drives the commit request path: virtual-to-physical lookup in the TLB, then a cache access, stalling on cache miss. Produces the registered writeback bundle for the writeback stage, and raises a fault on TLB miss or illegal op.

---
 rtl/cache_types_pkg.sv | 4 +
 rtl/cpu_commit_pkg.sv | 30 +++
 rtl/cpu_commit_perf_cnt.sv | 21 ++
 rtl/cpu_commit_stage.sv | 179 +++++++++++++++++
 tb/tb_cpu_commit_stage.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_types_pkg.sv
// Shared cache interface types used by the pipeline stages that talk to the data cache.
package cache_types_pkg;
    typedef enum logic {CACHE_WORD = 1'b0, CACHE_BYTE = 1'b1} cache_mode_e;
endpackage

// File: rtl/cpu_commit_pkg.sv
// Types for the commit stage: FSM states, latched op and writeback bundle.
// Struct field widths match the default stage parameters.
package cpu_commit_pkg;
    import cache_types_pkg::*;

    localparam int REG_W   = 32;
    localparam int DEST_W  = 5;

    typedef enum logic [1:0] {IDLE, TLB, CACHE} commit_state_e;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              tlb_write;
        cache_mode_e       mode;
        logic              mem_to_reg;
        logic              reg_write;
        logic [REG_W-1:0]  alu_result;
        logic [REG_W-1:0]  rb_data;
        logic [DEST_W-1:0] reg_dest;
    } commit_op_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  alu_result;
        logic [REG_W-1:0]  mem_data;
        logic [DEST_W-1:0] reg_dest;
    } wb_bundle_t;
endpackage

// File: rtl/cpu_commit_perf_cnt.sv
// Saturating TLB-miss and cache-stall event counters for the commit stage.
module cpu_commit_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        tlb_miss,
    input  logic        cache_stall,
    output logic [31:0] tlb_miss_cnt,
    output logic [31:0] cache_stall_cnt
);
    always_ff @(posedge clk) begin
        if (reset) begin
            tlb_miss_cnt    <= '0;
            cache_stall_cnt <= '0;
        end else begin
            if (tlb_miss && tlb_miss_cnt != '1)
                tlb_miss_cnt <= tlb_miss_cnt + 32'd1;
            if (cache_stall && cache_stall_cnt != '1)
                cache_stall_cnt <= cache_stall_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/cpu_commit_stage.sv
// Memory/commit stage: TLB lookup, cache access with miss stall, registered writeback.
// Optional COMMIT_PERF_CNT_EN adds TLB-miss and cache-stall counters.
module cpu_commit_stage
    import cache_types_pkg::*;
    import cpu_commit_pkg::*;
#(
    parameter int REG_WIDTH   = 32,
    parameter int VADDR_WIDTH = 32,
    parameter int PADDR_WIDTH = 20,
    parameter int NUM_REGS    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_mem_read,
    input  logic                        in_mem_write,
    input  logic                        in_tlb_write,
    input  logic                        in_byte,
    input  logic                        in_mem_to_reg,
    input  logic                        in_reg_write,
    input  logic [REG_WIDTH-1:0]        in_alu_result,
    input  logic [REG_WIDTH-1:0]        in_rb_data,
    input  logic [$clog2(NUM_REGS)-1:0] in_reg_dest,
    output logic                        tlb_enable,
    output logic                        tlb_write,
    output logic [VADDR_WIDTH-1:0]      tlb_addr,
    output logic [PADDR_WIDTH-1:0]      tlb_data,
    input  logic                        tlb_hit,
    output logic                        cache_read,
    output logic                        cache_write,
    output cache_mode_e                 cache_mode,
    output logic [VADDR_WIDTH-1:0]      cache_addr,
    output logic [REG_WIDTH-1:0]        cache_data_in,
    input  logic                        cache_hit,
    input  logic [REG_WIDTH-1:0]        cache_data_out,
    output logic                        wb_valid,
    output logic                        wb_reg_write,
    output logic                        wb_mem_to_reg,
    output logic [REG_WIDTH-1:0]        wb_alu_result,
    output logic [REG_WIDTH-1:0]        wb_mem_data,
    output logic [$clog2(NUM_REGS)-1:0] wb_reg_dest,
    output logic                        fault,
    output logic [VADDR_WIDTH-1:0]      fault_vaddr
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]                 tlb_miss_cnt,
    output logic [31:0]                 cache_stall_cnt
`endif
);
    commit_state_e          state, state_next;
    commit_op_t             op, in_op;
    wb_bundle_t             wb, wb_next;
    logic                   accept, wb_load, fault_set;
    logic [VADDR_WIDTH-1:0] fault_addr_next;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_op.mem_read   = in_mem_read;
        in_op.mem_write  = in_mem_write;
        in_op.tlb_write  = in_tlb_write;
        in_op.mode       = in_byte ? CACHE_BYTE : CACHE_WORD;
        in_op.mem_to_reg = in_mem_to_reg;
        in_op.reg_write  = in_reg_write;
        in_op.alu_result = in_alu_result;
        in_op.rb_data    = in_rb_data;
        in_op.reg_dest   = in_reg_dest;
    end

    always_comb begin
        state_next      = state;
        wb_load         = 1'b0;
        wb_next         = '0;
        fault_set       = 1'b0;
        fault_addr_next = '0;
        tlb_enable      = 1'b0;
        tlb_write       = 1'b0;
        tlb_addr        = '0;
        tlb_data        = '0;
        cache_read      = 1'b0;
        cache_write     = 1'b0;
        cache_mode      = CACHE_WORD;
        cache_addr      = '0;
        cache_data_in   = '0;
        case (state)
            IDLE: if (accept) begin
                if (in_mem_read && in_mem_write) begin
                    fault_set       = 1'b1;
                    fault_addr_next = in_alu_result;
                end else if (in_mem_read || in_mem_write || in_tlb_write) begin
                    state_next = TLB;
                end else begin
                    wb_load            = 1'b1;
                    wb_next.reg_write  = in_reg_write;
                    wb_next.mem_to_reg = in_mem_to_reg;
                    wb_next.alu_result = in_alu_result;
                    wb_next.reg_dest   = in_reg_dest;
                end
            end
            TLB: begin
                tlb_enable = 1'b1;
                tlb_write  = op.tlb_write;
                tlb_addr   = op.alu_result;
                tlb_data   = op.rb_data[PADDR_WIDTH-1:0];
                // A TLB write completes here regardless of tlb_hit and never writes a register
                if (op.tlb_write) begin
                    state_next         = IDLE;
                    wb_load            = 1'b1;
                    wb_next.mem_to_reg = op.mem_to_reg;
                    wb_next.alu_result = op.alu_result;
                    wb_next.reg_dest   = op.reg_dest;
                end else if (tlb_hit) begin
                    state_next = CACHE;
                end else begin
                    state_next      = IDLE;
                    fault_set       = 1'b1;
                    fault_addr_next = op.alu_result;
                end
            end
            CACHE: begin
                cache_read    = op.mem_read;
                cache_write   = op.mem_write;
                cache_mode    = op.mode;
                cache_addr    = op.alu_result;
                cache_data_in = op.rb_data;
                if (cache_hit) begin
                    state_next         = IDLE;
                    wb_load            = 1'b1;
                    wb_next.reg_write  = op.reg_write;
                    wb_next.mem_to_reg = op.mem_to_reg;
                    wb_next.alu_result = op.alu_result;
                    wb_next.reg_dest   = op.reg_dest;
                    if (op.mem_read)
                        wb_next.mem_data = (op.mode == CACHE_BYTE)
                            ? {{(REG_WIDTH-8){1'b0}}, cache_data_out[7:0]}
                            : cache_data_out;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= '0;
            wb          <= '0;
            wb_valid    <= 1'b0;
            fault       <= 1'b0;
            fault_vaddr <= '0;
        end else begin
            state    <= state_next;
            wb_valid <= wb_load;
            fault    <= fault_set;
            if (accept)    op          <= in_op;
            if (wb_load)   wb          <= wb_next;
            if (fault_set) fault_vaddr <= fault_addr_next;
        end
    end

    assign wb_reg_write  = wb.reg_write;
    assign wb_mem_to_reg = wb.mem_to_reg;
    assign wb_alu_result = wb.alu_result;
    assign wb_mem_data   = wb.mem_data;
    assign wb_reg_dest   = wb.reg_dest;

`ifdef COMMIT_PERF_CNT_EN
    cpu_commit_perf_cnt u_perf_cnt (
        .clk             (clk),
        .reset           (reset),
        .tlb_miss        (state == TLB && !op.tlb_write && !tlb_hit),
        .cache_stall     (state == CACHE && !cache_hit),
        .tlb_miss_cnt    (tlb_miss_cnt),
        .cache_stall_cnt (cache_stall_cnt)
    );
`endif
endmodule

// File: tb/tb_cpu_commit_stage.sv
// Self-checking bench for cpu_commit_stage: ALU vector table, directed memory/TLB
// sequences and randomized ops against an outcome-level reference model.
module tb_cpu_commit_stage;
    import cache_types_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic        in_mem_read = 1'b0, in_mem_write = 1'b0, in_tlb_write = 1'b0, in_byte = 1'b0;
    logic        in_mem_to_reg = 1'b0, in_reg_write = 1'b0;
    logic [31:0] in_alu_result = '0, in_rb_data = '0;
    logic [4:0]  in_reg_dest = '0;
    logic        tlb_enable, tlb_write, tlb_hit = 1'b0;
    logic [31:0] tlb_addr;
    logic [19:0] tlb_data;
    logic        cache_read, cache_write, cache_hit = 1'b0;
    cache_mode_e cache_mode;
    logic [31:0] cache_addr, cache_data_in, cache_data_out = '0;
    logic        wb_valid, wb_reg_write, wb_mem_to_reg, fault;
    logic [31:0] wb_alu_result, wb_mem_data, fault_vaddr;
    logic [4:0]  wb_reg_dest;
`ifdef COMMIT_PERF_CNT_EN
    logic [31:0] tlb_miss_cnt, cache_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cpu_commit_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_tlb_write(in_tlb_write),
        .in_byte(in_byte), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_result(in_alu_result), .in_rb_data(in_rb_data), .in_reg_dest(in_reg_dest),
        .tlb_enable(tlb_enable), .tlb_write(tlb_write), .tlb_addr(tlb_addr),
        .tlb_data(tlb_data), .tlb_hit(tlb_hit),
        .cache_read(cache_read), .cache_write(cache_write), .cache_mode(cache_mode),
        .cache_addr(cache_addr), .cache_data_in(cache_data_in), .cache_hit(cache_hit),
        .cache_data_out(cache_data_out),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_reg_dest(wb_reg_dest),
        .fault(fault), .fault_vaddr(fault_vaddr)
`ifdef COMMIT_PERF_CNT_EN
        , .tlb_miss_cnt(tlb_miss_cnt), .cache_stall_cnt(cache_stall_cnt)
`endif
    );

    typedef struct {
        logic        rd, wr, tw, byt, m2r, rw;
        logic [31:0] alu, rb;
        logic [4:0]  dest;
    } op_t;

    typedef struct {
        logic        got_wb, got_fault, both, done;
        int          lat, ready_low, tlb_cycles;
        logic        saw_tlb, saw_cache, tlb_wr_seen, mode_byte;
        logic [31:0] tlb_addr_seen, cache_addr_seen, cache_din_seen;
        logic [19:0] tlb_data_seen;
        logic        wb_rw, wb_m2r;
        logic [31:0] wb_alu, wb_mem, fva;
        logic [4:0]  wb_dest;
    } res_t;

    typedef struct {
        logic [31:0] alu;
        logic        rw, m2r;
        logic [4:0]  dest;
        logic [31:0] exp_alu;
        logic        exp_rw, exp_m2r;
        logic [4:0]  exp_dest;
    } alu_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one op, acts as TLB/cache responder, and records what the stage did.
    task automatic run_op(input op_t o, input bit hit, input int misses,
                          input logic [31:0] rdata, output res_t r);
        int  miss_left = misses;
        bit  was_miss;
        r = '{default: 0};
        in_valid = 1'b1; in_mem_read = o.rd; in_mem_write = o.wr; in_tlb_write = o.tw;
        in_byte = o.byt; in_mem_to_reg = o.m2r; in_reg_write = o.rw;
        in_alu_result = o.alu; in_rb_data = o.rb; in_reg_dest = o.dest;
        cache_data_out = rdata;
        tlb_hit = hit;
        while (!r.done && r.lat < 30) begin
            cache_hit = (cache_read || cache_write) && (miss_left == 0);
            was_miss  = (cache_read || cache_write) && !cache_hit;
            if (tlb_enable) begin
                r.saw_tlb = 1'b1; r.tlb_cycles++;
                r.tlb_wr_seen = tlb_write; r.tlb_addr_seen = tlb_addr; r.tlb_data_seen = tlb_data;
            end
            if (cache_read || cache_write) begin
                r.saw_cache = 1'b1; r.cache_addr_seen = cache_addr;
                r.cache_din_seen = cache_data_in; r.mode_byte = (cache_mode == CACHE_BYTE);
            end
            step();
            in_valid = 1'b0;
            r.lat++;
            if (was_miss) miss_left--;
            if (!in_ready) r.ready_low++;
            if (wb_valid || fault) begin
                r.done = 1'b1; r.got_wb = wb_valid; r.got_fault = fault;
                r.both = wb_valid && fault;
            end
        end
        r.wb_rw = wb_reg_write; r.wb_m2r = wb_mem_to_reg; r.wb_alu = wb_alu_result;
        r.wb_mem = wb_mem_data; r.wb_dest = wb_reg_dest; r.fva = fault_vaddr;
        tlb_hit = 1'b0; cache_hit = 1'b0;
        chk("op_done", r.done, 1);
    endtask

    // Reference model state: last completed writeback and last fault address.
    logic        m_rw = 0, m_m2r = 0;
    logic [31:0] m_alu = 0, m_mem = 0, m_fva = 0;
    logic [4:0]  m_dest = 0;

    task automatic model_check(input op_t o, input bit hit, input int misses,
                               input logic [31:0] rdata, input res_t r);
        bit is_mem = o.rd || o.wr;
        bit illegal = o.rd && o.wr;
        bit e_wb, e_fault, e_tlb, e_cache;
        int e_lat;
        if (illegal) begin
            e_fault = 1; e_wb = 0; e_tlb = 0; e_cache = 0; e_lat = 1; m_fva = o.alu;
        end else if (o.tw) begin
            e_fault = 0; e_wb = 1; e_tlb = 1; e_cache = 0; e_lat = 2;
            m_rw = 0; m_m2r = o.m2r; m_alu = o.alu; m_mem = 0; m_dest = o.dest;
        end else if (is_mem && !hit) begin
            e_fault = 1; e_wb = 0; e_tlb = 1; e_cache = 0; e_lat = 2; m_fva = o.alu;
        end else if (is_mem) begin
            e_fault = 0; e_wb = 1; e_tlb = 1; e_cache = 1; e_lat = 3 + misses;
            m_rw = o.rw; m_m2r = o.m2r; m_alu = o.alu; m_dest = o.dest;
            m_mem = o.wr ? 32'd0 : (o.byt ? (rdata & 32'hFF) : rdata);
        end else begin
            e_fault = 0; e_wb = 1; e_tlb = 0; e_cache = 0; e_lat = 1;
            m_rw = o.rw; m_m2r = o.m2r; m_alu = o.alu; m_mem = 0; m_dest = o.dest;
        end
        chk("rnd_wb_valid", r.got_wb, e_wb);
        chk("rnd_fault", r.got_fault, e_fault);
        chk("rnd_latency", r.lat, e_lat);
        chk("rnd_ready_low", r.ready_low, e_lat - 1);
        chk("rnd_tlb_access", r.saw_tlb, e_tlb);
        chk("rnd_cache_access", r.saw_cache, e_cache);
        chk("rnd_wb_alu", r.wb_alu, m_alu);
        chk("rnd_wb_mem", r.wb_mem, m_mem);
        chk("rnd_wb_dest", r.wb_dest, m_dest);
        chk("rnd_wb_rw", r.wb_rw, m_rw);
        chk("rnd_fault_vaddr", r.fva, m_fva);
        if (r.saw_tlb) chk("rnd_tlb_addr", r.tlb_addr_seen, o.alu);
        if (r.saw_cache) begin
            chk("rnd_cache_addr", r.cache_addr_seen, o.alu);
            chk("rnd_cache_din", r.cache_din_seen, o.rb);
            chk("rnd_cache_mode", r.mode_byte, o.byt);
        end
    endtask

    initial begin
        alu_vec_t vecs[4];
        op_t      o;
        res_t     r;

        vecs[0] = '{32'h0000_1234, 1, 0, 5'd5,  32'h0000_1234, 1, 0, 5'd5};
        vecs[1] = '{32'hFFFF_FFFF, 1, 1, 5'd31, 32'hFFFF_FFFF, 1, 1, 5'd31};
        vecs[2] = '{32'h0000_0000, 0, 0, 5'd0,  32'h0000_0000, 0, 0, 5'd0};
        vecs[3] = '{32'hA5A5_0001, 1, 0, 5'd17, 32'hA5A5_0001, 1, 0, 5'd17};

        // Reset state
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_fault", fault, 0);
        chk("rst_tlb_enable", tlb_enable, 0);
        chk("rst_cache_read", cache_read, 0);
        chk("rst_wb_alu", wb_alu_result, 0);
        chk("rst_fault_vaddr", fault_vaddr, 0);
`ifdef COMMIT_PERF_CNT_EN
        chk("rst_tlb_miss_cnt", tlb_miss_cnt, 0);
        chk("rst_stall_cnt", cache_stall_cnt, 0);
`endif
        reset = 1'b0;
        step();

        // Back-to-back ALU ops from the vector table
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_mem_read = 0; in_mem_write = 0; in_tlb_write = 0; in_byte = 0;
            in_alu_result = vecs[i].alu; in_reg_write = vecs[i].rw;
            in_mem_to_reg = vecs[i].m2r; in_reg_dest = vecs[i].dest;
            chk("alu_in_ready", in_ready, 1);
            step();
            chk("alu_wb_valid", wb_valid, 1);
            chk("alu_wb_alu", wb_alu_result, vecs[i].exp_alu);
            chk("alu_wb_dest", wb_reg_dest, vecs[i].exp_dest);
            chk("alu_wb_rw", wb_reg_write, vecs[i].exp_rw);
            chk("alu_wb_m2r", wb_mem_to_reg, vecs[i].exp_m2r);
            chk("alu_wb_mem", wb_mem_data, 0);
        end
        in_valid = 1'b0;
        step();
        chk("alu_wb_pulse_end", wb_valid, 0);
        chk("alu_wb_hold", wb_alu_result, 32'hA5A5_0001);

        // WORD load, TLB hit, three cache miss cycles
        o = '{rd: 1, wr: 0, tw: 0, byt: 0, m2r: 1, rw: 1, alu: 32'h40, rb: 32'h0, dest: 5'd3};
        run_op(o, 1, 3, 32'hDEAD_BEEF, r);
        chk("word_wb", r.got_wb, 1);
        chk("word_latency", r.lat, 6);
        chk("word_ready_low", r.ready_low, 5);
        chk("word_mem_data", r.wb_mem, 32'hDEAD_BEEF);
        chk("word_cache_addr", r.cache_addr_seen, 32'h40);
        chk("word_mode", r.mode_byte, 0);
        chk("word_dest", r.wb_dest, 3);
        chk("word_no_both", r.both, 0);
`ifdef COMMIT_PERF_CNT_EN
        chk("word_stall_cnt", cache_stall_cnt, 3);
`endif

        // BYTE load, immediate hit
        o = '{rd: 1, wr: 0, tw: 0, byt: 1, m2r: 1, rw: 1, alu: 32'h44, rb: 32'h0, dest: 5'd4};
        run_op(o, 1, 0, 32'hAABB_CCF0, r);
        chk("byte_latency", r.lat, 3);
        chk("byte_mem_data", r.wb_mem, 32'h0000_00F0);
        chk("byte_mode", r.mode_byte, 1);

        // Store with TLB miss
        o = '{rd: 0, wr: 1, tw: 0, byt: 0, m2r: 0, rw: 0, alu: 32'h80, rb: 32'h55, dest: 5'd0};
        run_op(o, 0, 0, 32'h0, r);
        chk("stmiss_fault", r.got_fault, 1);
        chk("stmiss_no_wb", r.got_wb, 0);
        chk("stmiss_no_cache", r.saw_cache, 0);
        chk("stmiss_fault_vaddr", r.fva, 32'h80);
        chk("stmiss_latency", r.lat, 2);
        step();
        chk("stmiss_fault_pulse_end", fault, 0);
        chk("stmiss_fault_vaddr_hold", fault_vaddr, 32'h80);
`ifdef COMMIT_PERF_CNT_EN
        chk("stmiss_tlb_miss_cnt", tlb_miss_cnt, 1);
`endif

        // TLB write
        o = '{rd: 0, wr: 0, tw: 1, byt: 0, m2r: 0, rw: 1, alu: 32'h1000, rb: 32'hABCDE, dest: 5'd9};
        run_op(o, 0, 0, 32'h0, r);
        chk("tlbw_write_seen", r.tlb_wr_seen, 1);
        chk("tlbw_data", r.tlb_data_seen, 32'hABCDE);
        chk("tlbw_addr", r.tlb_addr_seen, 32'h1000);
        chk("tlbw_one_cycle", r.tlb_cycles, 1);
        chk("tlbw_wb", r.got_wb, 1);
        chk("tlbw_wb_rw", r.wb_rw, 0);
        chk("tlbw_latency", r.lat, 2);
`ifdef COMMIT_PERF_CNT_EN
        chk("tlbw_no_miss_cnt", tlb_miss_cnt, 1);
`endif

        // Illegal read+write op
        o = '{rd: 1, wr: 1, tw: 0, byt: 0, m2r: 0, rw: 1, alu: 32'h200, rb: 32'h0, dest: 5'd1};
        run_op(o, 1, 0, 32'h0, r);
        chk("illegal_fault", r.got_fault, 1);
        chk("illegal_no_wb", r.got_wb, 0);
        chk("illegal_no_tlb", r.saw_tlb, 0);
        chk("illegal_fault_vaddr", r.fva, 32'h200);
        chk("illegal_latency", r.lat, 1);

        // Reset during a cache stall abandons the op
        in_valid = 1'b1; in_mem_read = 1; in_mem_write = 0; in_tlb_write = 0; in_byte = 0;
        in_alu_result = 32'h300; in_reg_write = 1; tlb_hit = 1'b1; cache_hit = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        chk("rstmid_cache_read", cache_read, 1);
        chk("rstmid_ready_low", in_ready, 0);
        reset = 1'b1;
        step();
        chk("rstmid_cache_drop", cache_read, 0);
        chk("rstmid_in_ready", in_ready, 1);
        chk("rstmid_no_wb", wb_valid, 0);
        chk("rstmid_no_fault", fault, 0);
        chk("rstmid_wb_cleared", wb_alu_result, 0);
        chk("rstmid_fva_cleared", fault_vaddr, 0);
        reset = 1'b0; tlb_hit = 1'b0;
        step();
        chk("rstmid_still_no_wb", wb_valid, 0);

        // Randomized ops against the reference model
        for (int n = 0; n < 150; n++) begin
            int  kind = $urandom_range(0, 9);
            bit  hit  = ($urandom_range(0, 3) != 0);
            int  ms   = $urandom_range(0, 3);
            logic [31:0] rdat = $urandom;
            o.rd = (kind >= 3 && kind <= 5) || kind == 9;
            o.wr = (kind == 6 || kind == 7) || kind == 9;
            o.tw = (kind == 8);
            o.byt = $urandom_range(0, 1);
            o.m2r = $urandom_range(0, 1);
            o.rw  = $urandom_range(0, 1);
            o.alu = $urandom;
            o.rb  = $urandom;
            o.dest = 5'($urandom_range(0, 31));
            run_op(o, hit, ms, rdat, r);
            chk("rnd_no_both", r.both, 0);
            model_check(o, hit, ms, rdat, r);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
